// File: rtl/enabled_dff.sv
// Load-enabled register: one 2:1 select feeding one resettable flop per bit.
// All bits share enable and a synchronous active-high reset.

module enabled_dff_bit (
   input  logic clk,
   input  logic reset,
   input  logic d,
   input  logic enable,
   output logic q
);
   logic sel;

   // enable=0 recirculates the stored value instead of gating the clock
   always_comb begin
      sel = q;
      if (enable) sel = d;
   end

   always_ff @(posedge clk) begin
      if (reset) q <= 1'b0;
      else       q <= sel;
   end
endmodule

module enabled_dff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic             enable,
   output logic [WIDTH-1:0] q
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      enabled_dff_bit u_bit (
         .clk    (clk),
         .reset  (reset),
         .d      (d[i]),
         .enable (enable),
         .q      (q[i])
      );
   end
endmodule

// File: tb/tb_enabled_dff.sv
// Scoreboard bench for enabled_dff at WIDTH=8 and WIDTH=1; the driver queues
// the hand-computed q for each edge and a monitor checks it just after that edge.

module tb_enabled_dff;
   logic       clk = 1'b0;
   logic       reset, enable;
   logic [7:0] d;
   logic [7:0] q8;
   logic [0:0] q1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   enabled_dff #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .d(d), .enable(enable), .q(q8)
   );
   enabled_dff #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .d(d[0:0]), .enable(enable), .q(q1)
   );

   // monitor: one expected entry per rising edge once stimulus has begun
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_chk++;
         if (q8 !== e.exp) begin
            n_fail++;
            $display("FAIL %s w8: q=%h expected %h", e.name, q8, e.exp);
         end
         n_chk++;
         if (q1 !== e.exp[0:0]) begin
            n_fail++;
            $display("FAIL %s w1: q=%b expected %b", e.name, q1, e.exp[0]);
         end
      end
   end

   // drive one edge's inputs and queue the q expected after that edge
   task automatic vec(input logic r, input logic en, input logic [7:0] dv,
                      input logic [7:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      reset  = r;
      enable = en;
      d      = dv;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      d      = 8'h00;
      repeat (2) @(negedge clk);

      vec(1, 1, 8'h01, 8'h00, "rst_en1");
      // enable=1, d toggles every 4 edges; q lags d by one edge
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            vec(0, 1, (k % 2 == 0) ? 8'h01 : 8'h00,
                (k % 2 == 0) ? 8'h01 : 8'h00, "follow");
      vec(1, 0, 8'h00, 8'h00, "rst_en0");
      vec(0, 0, 8'h00, 8'h00, "post_rst");
      // enable=0: d activity must not reach q
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            vec(0, 0, (k % 2 == 0) ? 8'h01 : 8'h00, 8'h00, "hold0");

      vec(0, 1, 8'hA5, 8'hA5, "load_a5");
      for (int j = 0; j < 3; j++) vec(0, 0, 8'h3C, 8'hA5, "hold_a5");
      vec(1, 0, 8'h3C, 8'h00, "rst_a5");

      vec(0, 1, 8'hFF, 8'hFF, "load_ff");
      for (int j = 0; j < 3; j++) vec(1, 1, 8'hFF, 8'h00, "rst_multi");
      vec(0, 1, 8'h5A, 8'h5A, "rst_release");
      vec(0, 1, 8'hC3, 8'hC3, "change_en");

      // enable and d pulse mid-cycle but are back to hold at the edge
      vec(0, 0, 8'h00, 8'hC3, "glitch_en");
      #2 enable = 1'b1; d = 8'h0F;
      #1 enable = 1'b0; d = 8'h00;
      // reset pulse between edges must not clear q
      vec(0, 0, 8'h00, 8'hC3, "glitch_rst");
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      vec(0, 1, 8'h81, 8'h81, "final_load");

      begin : drain
         int cyc;
         cyc = 0;
         while (sb.size() > 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
         end
         #2;
         if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
